// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: locks to the slot marker on tuser[0],
// drops every CP and forwards NFFT-sample symbol bodies with tlast.
module ofdm_cp_remover #(
   parameter int WIDTH            = 12,
   parameter int NUM_CHANNELS     = 2,
   parameter int AXIS_DATA_WIDTH  = NUM_CHANNELS * 2 * WIDTH,
   parameter int AXIS_TUSER_WIDTH = 1,
   parameter int NFFT             = 2048,
   parameter int CP_LEN_FIRST     = 160,
   parameter int CP_LEN           = 144,
   parameter int SYMS_PER_SLOT    = 7
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic                             in_sync,
   output logic [$clog2(SYMS_PER_SLOT)-1:0] symbol_idx,
   output logic [15:0]                      resync_count,
   output logic                             symbol_abort
);

   localparam int CMAX0 = (NFFT > CP_LEN_FIRST) ? NFFT : CP_LEN_FIRST;
   localparam int CMAX  = (CMAX0 > CP_LEN) ? CMAX0 : CP_LEN;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int SW    = $clog2(SYMS_PER_SLOT);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_CP,
      S_BODY
   } state_t;

   state_t                      r_state;
   state_t                      w_nxt_state;
   logic [CW-1:0]               r_cnt;
   logic [CW-1:0]               w_nxt_cnt;
   logic [SW-1:0]               r_sym;
   logic [SW-1:0]               w_nxt_sym;
   logic [CW-1:0]               w_cplen;
   logic                        w_tready;
   logic                        w_acc;
   logic                        w_mk;
   logic                        w_load;
   logic                        w_first;
   logic                        w_last;
   logic                        w_resync;
   logic                        w_abort;
   logic [AXIS_DATA_WIDTH-1:0]  r_tdata;
   logic [AXIS_TUSER_WIDTH-1:0] r_tuser;
   logic                        r_tlast;
   logic                        r_tvalid;
   logic                        r_in_sync;
   logic [15:0]                 r_resync;
   logic                        r_abort;
   logic                        w_unused;

   // Input tlast carries no meaning here; symbol framing is rebuilt.
   assign w_unused = s_axis_tlast;

   // Input is only held back while a body beat would overrun the output.
   assign w_tready = !enable || (r_state != S_BODY) ||
                     !r_tvalid || m_axis_tready;
   assign w_acc    = s_axis_tvalid && w_tready;
   assign w_mk     = s_axis_tuser[0];
   assign w_cplen  = (r_sym == '0) ? CW'(CP_LEN_FIRST) : CW'(CP_LEN);

   // Next-state: CP/body sequencing, flywheel and marker realignment.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_sym   = r_sym;
      w_load      = 1'b0;
      w_first     = 1'b0;
      w_last      = 1'b0;
      w_resync    = 1'b0;
      w_abort     = 1'b0;
      if (!enable) begin
         w_nxt_state = S_SEARCH;
         w_nxt_cnt   = '0;
         w_nxt_sym   = '0;
      end else if (w_acc) begin
         unique case (r_state)
            S_SEARCH: begin
               if (w_mk) begin
                  w_nxt_state = S_CP;
                  w_nxt_cnt   = CW'(1);
                  w_nxt_sym   = '0;
               end
            end
            S_CP: begin
               if (w_mk && !((r_sym == '0) && (r_cnt == '0))) begin
                  w_resync    = 1'b1;
                  w_nxt_state = S_CP;
                  w_nxt_cnt   = CW'(1);
                  w_nxt_sym   = '0;
               end else if (r_cnt == w_cplen - CW'(1)) begin
                  w_nxt_state = S_BODY;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end
            S_BODY: begin
               if (w_mk) begin
                  w_resync    = 1'b1;
                  w_abort     = 1'b1;
                  w_nxt_state = S_CP;
                  w_nxt_cnt   = CW'(1);
                  w_nxt_sym   = '0;
               end else begin
                  w_load  = 1'b1;
                  w_first = (r_cnt == '0);
                  w_last  = (r_cnt == CW'(NFFT - 1));
                  if (w_last) begin
                     w_nxt_state = S_CP;
                     w_nxt_cnt   = '0;
                     if (r_sym == SW'(SYMS_PER_SLOT - 1)) begin
                        w_nxt_sym = '0;
                     end else begin
                        w_nxt_sym = r_sym + 1'b1;
                     end
                  end else begin
                     w_nxt_cnt = r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               w_nxt_state = S_SEARCH;
               w_nxt_cnt   = '0;
               w_nxt_sym   = '0;
            end
         endcase
      end
   end

   // State, counters and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_SEARCH;
         r_cnt     <= '0;
         r_sym     <= '0;
         r_in_sync <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_sym     <= w_nxt_sym;
         r_in_sync <= (w_nxt_state != S_SEARCH);
         r_abort   <= w_abort;
      end
   end

   // Saturating count of markers that arrived off the expected slot start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resync <= '0;
      end else if (w_resync && (r_resync != 16'hFFFF)) begin
         r_resync <= r_resync + 16'd1;
      end
   end

   // Single output register: load on a body accept, clear on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tdata  <= '0;
         r_tuser  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= s_axis_tdata;
         r_tuser  <= AXIS_TUSER_WIDTH'(w_first);
         r_tlast  <= w_last;
         r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign s_axis_tready = w_tready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;
   assign in_sync       = r_in_sync;
   assign symbol_idx    = r_sym;
   assign resync_count  = r_resync;
   assign symbol_abort  = r_abort;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed bench for ofdm_cp_remover with small symbol geometry:
// NFFT=16, CP 6/4, 3 symbols per slot; beats carry their index.
module tb_ofdm_cp_remover;

   localparam int DW   = 48;
   localparam int NFFT = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [0:0]    s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [0:0]    m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          in_sync;
   logic [1:0]    symbol_idx;
   logic [15:0]   resync_count;
   logic          symbol_abort;

   int vecs = 0;
   int errs = 0;
   int idx = 0;
   int viol = 0;
   int aborts = 0;
   int mkpos = 0;
   bit en_drv = 1'b1;
   bit rnd_rdy = 1'b0;
   bit mk_at [0:511];
   bit exp_body [0:511];
   int outq [$];
   int expq [$];

   ofdm_cp_remover #(
      .WIDTH(12),
      .NUM_CHANNELS(2),
      .AXIS_DATA_WIDTH(DW),
      .AXIS_TUSER_WIDTH(1),
      .NFFT(NFFT),
      .CP_LEN_FIRST(6),
      .CP_LEN(4),
      .SYMS_PER_SLOT(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .in_sync(in_sync),
      .symbol_idx(symbol_idx),
      .resync_count(resync_count),
      .symbol_abort(symbol_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, observe handshakes before posedge.
   task automatic cyc(input bit v);
      bit rdy;
      bit acc;
      @(negedge clk);
      rdy = rnd_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
      enable        = en_drv;
      s_axis_tvalid = v;
      s_axis_tdata  = DW'(idx);
      s_axis_tuser  = mk_at[idx];
      m_axis_tready = rdy;
      #1;
      acc = v && s_axis_tready;
      if (!s_axis_tready && !(m_axis_tvalid && !m_axis_tready))
         viol++;
      if (v && !s_axis_tready && !exp_body[idx])
         viol++;
      if (m_axis_tvalid && m_axis_tready)
         outq.push_back(int'(m_axis_tdata[15:0]) * 4 +
                        int'(m_axis_tuser[0]) * 2 +
                        int'(m_axis_tlast));
      if (symbol_abort)
         aborts++;
      @(posedge clk);
      if (acc)
         idx++;
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (idx < target && n < 3000) begin
         cyc(1'b1);
         n++;
      end
      if (idx < target)
         check("timeout", idx, target);
   endtask

   task automatic drain();
      rnd_rdy = 1'b0;
      repeat (4) cyc(1'b0);
   endtask

   task automatic add_run(input int s, input int len);
      for (int k = 0; k < len; k++) begin
         expq.push_back((s + k) * 4 + ((k == 0) ? 2 : 0) +
                        ((k == NFFT - 1) ? 1 : 0));
         exp_body[s + k] = 1'b1;
      end
   endtask

   task automatic verify(input string tag);
      int n;
      check({tag, "_count"}, outq.size(), expq.size());
      n = (outq.size() < expq.size()) ? outq.size() : expq.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), outq[i], expq[i]);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      en_drv        = 1'b1;
      enable        = 1'b1;
      rnd_rdy       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = '0;
      m_axis_tready = 1'b1;
      idx    = 0;
      viol   = 0;
      aborts = 0;
      outq.delete();
      expq.delete();
      for (int i = 0; i < 512; i++) begin
         mk_at[i]    = 1'b0;
         exp_body[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      #1;
      check("rst_tvalid", int'(m_axis_tvalid), 0);
      check("rst_tdata", int'(m_axis_tdata[15:0]), 0);
      check("rst_tuser", int'(m_axis_tuser), 0);
      check("rst_tlast", int'(m_axis_tlast), 0);
      check("rst_insync", int'(in_sync), 0);
      check("rst_symidx", int'(symbol_idx), 0);
      check("rst_resync", int'(resync_count), 0);
      check("rst_abort", int'(symbol_abort), 0);
      check("rst_sready", int'(s_axis_tready), 1);

      // Lock on marker 5, then a second slot by flywheel.
      mk_at[5] = 1'b1;
      add_run(11, 16);
      add_run(31, 16);
      add_run(51, 16);
      add_run(73, 16);
      add_run(93, 16);
      add_run(113, 16);
      run_to(5);
      #1 check("insync_pre", int'(in_sync), 0);
      run_to(6);
      #1 check("insync_lock", int'(in_sync), 1);
      run_to(35);
      #1 check("symidx_mid", int'(symbol_idx), 1);
      run_to(129);
      drain();
      verify("lock");
      check("lock_resync", int'(resync_count), 0);
      check("lock_symidx", int'(symbol_idx), 0);
      check("lock_ready", viol, 0);

      // Early marker in symbol 1 CP.
      do_reset();
      mk_at[5]  = 1'b1;
      mk_at[30] = 1'b1;
      add_run(11, 16);
      add_run(36, 16);
      add_run(56, 16);
      run_to(72);
      drain();
      verify("early");
      check("early_resync", int'(resync_count), 1);
      check("early_abort", aborts, 0);

      // Marker at body sample 8 of symbol 0.
      do_reset();
      mk_at[5]  = 1'b1;
      mk_at[19] = 1'b1;
      add_run(11, 8);
      add_run(25, 16);
      run_to(41);
      drain();
      verify("abort");
      check("abort_resync", int'(resync_count), 1);
      check("abort_pulses", aborts, 1);
      check("abort_symidx", int'(symbol_idx), 1);

      // Random output backpressure over two slots.
      do_reset();
      mk_at[5] = 1'b1;
      add_run(11, 16);
      add_run(31, 16);
      add_run(51, 16);
      add_run(73, 16);
      add_run(93, 16);
      add_run(113, 16);
      rnd_rdy = 1'b1;
      run_to(129);
      drain();
      verify("bp");
      check("bp_ready", viol, 0);

      // Disable mid-body, then relock.
      do_reset();
      mk_at[5] = 1'b1;
      mk_at[8] = 1'b1;
      add_run(14, 6);
      run_to(20);
      en_drv = 1'b0;
      repeat (3) cyc(1'b1);
      #1;
      check("dis_insync", int'(in_sync), 0);
      check("dis_symidx", int'(symbol_idx), 0);
      check("dis_resync", int'(resync_count), 1);
      en_drv = 1'b1;
      mkpos = idx + 2;
      mk_at[mkpos] = 1'b1;
      add_run(mkpos + 6, 16);
      run_to(mkpos + 22);
      drain();
      verify("enable");
      check("en_resync", int'(resync_count), 1);
      check("en_ready", viol, 0);

      // Asynchronous reset mid-body, then relock.
      do_reset();
      mk_at[5] = 1'b1;
      add_run(11, 3);
      run_to(15);
      #3;
      check("prerst_tvalid", int'(m_axis_tvalid), 1);
      rst_n = 1'b0;
      #1;
      check("arst_tvalid", int'(m_axis_tvalid), 0);
      check("arst_tdata", int'(m_axis_tdata[15:0]), 0);
      check("arst_tuser", int'(m_axis_tuser), 0);
      check("arst_tlast", int'(m_axis_tlast), 0);
      check("arst_insync", int'(in_sync), 0);
      check("arst_symidx", int'(symbol_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mkpos = idx + 3;
      mk_at[mkpos] = 1'b1;
      add_run(mkpos + 6, 16);
      run_to(mkpos + 22);
      drain();
      verify("reset");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
